// File: rtl/tile_load_ctrl_if.sv
// Handshake and buffer-control bundle between the tile write sequencer and its
// neighbours: the input beat stream, the tiling buffer and the tile consumer.
interface tile_load_ctrl_if #(
  parameter int SIZE_OF_INPUT = 128,
  parameter int CNT_WIDTH     = 16
);
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic [SIZE_OF_INPUT-1:0] s_data_i;
  logic [3:0]               wr_en_o;
  logic [SIZE_OF_INPUT-1:0] wr_data_o;
  logic                     rd_en_o;
  logic [3:0]               is_empty_i;
  logic [3:0]               is_full_i;
  logic                     tile_valid_o;
  logic                     tile_ready_i;
  logic                     flush_i;
  logic [CNT_WIDTH-1:0]     tile_cnt_o;
  logic                     err_o;

  modport slave (
    input  s_valid_i, s_data_i, is_empty_i, is_full_i, tile_ready_i, flush_i,
    output s_ready_o, wr_en_o, wr_data_o, rd_en_o, tile_valid_o, tile_cnt_o, err_o
  );

  modport master (
    output s_valid_i, s_data_i, is_empty_i, is_full_i, tile_ready_i, flush_i,
    input  s_ready_o, wr_en_o, wr_data_o, rd_en_o, tile_valid_o, tile_cnt_o, err_o
  );
endinterface

// File: rtl/tile_load_ctrl.sv
// Write-side sequencer for the four-quadrant tiling buffer: fills quadrants
// 0/2 then 1/3, presents the full tile, releases it and waits for empty.
module tile_load_ctrl #(
  parameter int SIZE_OF_INPUT  = 128,
  parameter int SIZE_OF_BUFFER = 8,
  parameter int CNT_WIDTH      = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  tile_load_ctrl_if.slave bus
);
  localparam int DEPTH = SIZE_OF_BUFFER / 2;
  localparam int BCW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    FILL_A,
    FILL_B,
    WAIT_FULL,
    PRESENT,
    DRAIN
  } state_t;

  state_t                   r_state;
  logic [BCW-1:0]           r_bcnt;
  logic [3:0]               r_wr_en;
  logic [SIZE_OF_INPUT-1:0] r_wr_data;
  logic                     r_rd_en;
  logic                     r_tile_valid;
  logic [CNT_WIDTH-1:0]     r_tile_cnt;
  logic                     r_err;

  logic       w_ready;
  logic       w_hs;
  logic       w_last_beat;
  logic [3:0] w_pattern;

  // Ready depends only on state and flush so upstream never sees a combinational loop
  assign w_ready     = ((r_state == FILL_A) || (r_state == FILL_B)) && !bus.flush_i;
  assign w_hs        = w_ready && bus.s_valid_i;
  assign w_last_beat = (r_bcnt == BCW'(DEPTH - 1));
  assign w_pattern   = (r_state == FILL_A) ? 4'b0101 : 4'b1010;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= FILL_A;
      r_bcnt       <= '0;
      r_wr_en      <= '0;
      r_wr_data    <= '0;
      r_rd_en      <= 1'b0;
      r_tile_valid <= 1'b0;
      r_tile_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en <= '0;
      r_rd_en <= 1'b0;

      if (w_hs) begin
        r_wr_en   <= w_pattern;
        r_wr_data <= bus.s_data_i;
        if (|(w_pattern & bus.is_full_i)) begin
          r_err <= 1'b1;
        end
      end

      // Flush overrides every transition, including a simultaneous tile accept
      if (bus.flush_i) begin
        r_state      <= DRAIN;
        r_bcnt       <= '0;
        r_tile_valid <= 1'b0;
        if (r_state != DRAIN) begin
          r_rd_en <= 1'b1;
        end
      end else begin
        unique case (r_state)
          FILL_A: begin
            if (w_hs) begin
              if (w_last_beat) begin
                r_bcnt  <= '0;
                r_state <= FILL_B;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
          FILL_B: begin
            if (w_hs) begin
              if (w_last_beat) begin
                r_bcnt  <= '0;
                r_state <= WAIT_FULL;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
          WAIT_FULL: begin
            if (bus.is_full_i == 4'hF) begin
              r_state      <= PRESENT;
              r_tile_valid <= 1'b1;
            end
          end
          PRESENT: begin
            if (bus.tile_ready_i) begin
              r_state      <= DRAIN;
              r_tile_valid <= 1'b0;
              r_rd_en      <= 1'b1;
              r_tile_cnt   <= r_tile_cnt + 1'b1;
            end
          end
          DRAIN: begin
            if (bus.is_empty_i == 4'hF) begin
              r_state <= FILL_A;
            end
          end
          default: r_state <= FILL_A;
        endcase
      end
    end
  end

  assign bus.s_ready_o    = w_ready;
  assign bus.wr_en_o      = r_wr_en;
  assign bus.wr_data_o    = r_wr_data;
  assign bus.rd_en_o      = r_rd_en;
  assign bus.tile_valid_o = r_tile_valid;
  assign bus.tile_cnt_o   = r_tile_cnt;
  assign bus.err_o        = r_err;
endmodule

// File: tb/tb_tile_load_ctrl.sv
// Directed bench for tile_load_ctrl with a small quadrant-occupancy buffer model.
module tb_tile_load_ctrl;
  localparam int W     = 128;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic force_full;
  logic [3:0] model_full;
  logic [3:0] model_empty;
  int qcnt[4];
  int n_checks;
  int n_pass;

  tile_load_ctrl_if #(.SIZE_OF_INPUT(W), .CNT_WIDTH(16)) bus ();

  tile_load_ctrl #(
    .SIZE_OF_INPUT (W),
    .SIZE_OF_BUFFER(2 * DEPTH),
    .CNT_WIDTH     (16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quadrant occupancy: counts writes, cleared by the release pulse
  always @(posedge clk) begin
    if (rst || bus.rd_en_o) begin
      for (int q = 0; q < 4; q++) qcnt[q] <= 0;
    end else begin
      for (int q = 0; q < 4; q++) if (bus.wr_en_o[q]) qcnt[q] <= qcnt[q] + 1;
    end
  end

  always_comb begin
    model_full  = '0;
    model_empty = '0;
    for (int q = 0; q < 4; q++) begin
      model_full[q]  = (qcnt[q] >= DEPTH);
      model_empty[q] = (qcnt[q] == 0);
    end
  end

  assign bus.is_full_i  = force_full ? 4'b0001 : model_full;
  assign bus.is_empty_i = model_empty;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   exp_wen;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.tile_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int c = 0; c < 50 && !bus.s_ready_o; c++) step();
    check(name, W'(bus.s_ready_o), W'(1));
  endtask

  task automatic wait_tile(input string name);
    for (int c = 0; c < 50 && !bus.tile_valid_o; c++) step();
    check(name, W'(bus.tile_valid_o), W'(1));
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    bus.s_valid_i = 1'b1;
    bus.s_data_i = d;
    step();
    bus.s_valid_i = 1'b0;
  endtask

  int beats;
  int wr_cycles;
  logic hs;

  initial begin
    n_checks = 0;
    n_pass = 0;
    force_full = 1'b0;
    bus.s_data_i = '0;
    for (int i = 0; i < 8; i++) begin
      vecs[i].data    = {16{8'(i + 1)}};
      vecs[i].exp_wen = (i < DEPTH) ? 4'b0101 : 4'b1010;
    end

    // Reset state
    do_reset();
    check("rst_wr_en", W'(bus.wr_en_o), W'(0));
    check("rst_wr_data", bus.wr_data_o, '0);
    check("rst_rd_en", W'(bus.rd_en_o), W'(0));
    check("rst_tile_valid", W'(bus.tile_valid_o), W'(0));
    check("rst_tile_cnt", W'(bus.tile_cnt_o), W'(0));
    check("rst_err", W'(bus.err_o), W'(0));
    check("rst_s_ready", W'(bus.s_ready_o), W'(1));

    // Full-rate fill from the vector table
    for (int i = 0; i < 8; i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i = vecs[i].data;
      #1;
      check("fill_ready", W'(bus.s_ready_o), W'(1));
      step();
      check("fill_wr_en", W'(bus.wr_en_o), W'(vecs[i].exp_wen));
      check("fill_wr_data", bus.wr_data_o, vecs[i].data);
    end
    bus.s_valid_i = 1'b0;
    step();
    check("idle_wr_en", W'(bus.wr_en_o), W'(0));
    check("hold_wr_data", bus.wr_data_o, vecs[7].data);
    check("pre_full_tile_valid", W'(bus.tile_valid_o), W'(0));
    step();
    check("tile_valid_rise", W'(bus.tile_valid_o), W'(1));

    // Downstream stall in PRESENT
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_tile_valid", W'(bus.tile_valid_o), W'(1));
      check("stall_outputs", W'({bus.s_ready_o, bus.wr_en_o, bus.rd_en_o}), W'(0));
    end
    bus.tile_ready_i = 1'b1;
    step();
    bus.tile_ready_i = 1'b0;
    check("accept_rd_en", W'(bus.rd_en_o), W'(1));
    check("accept_tile_valid", W'(bus.tile_valid_o), W'(0));
    check("accept_tile_cnt", W'(bus.tile_cnt_o), W'(1));
    step();
    check("rd_en_single", W'(bus.rd_en_o), W'(0));
    wait_ready("drain_exit");

    // Three tiles with random input gaps
    do_reset();
    beats = 0;
    wr_cycles = 0;
    bus.tile_ready_i = 1'b1;
    for (int c = 0; c < 600 && bus.tile_cnt_o != 16'd3; c++) begin
      bus.s_valid_i = (beats < 24) && ($urandom_range(0, 1) == 1);
      bus.s_data_i = W'(beats);
      #1;
      hs = bus.s_valid_i && bus.s_ready_o;
      step();
      if (hs) beats++;
      if (|bus.wr_en_o) wr_cycles++;
    end
    bus.s_valid_i = 1'b0;
    bus.tile_ready_i = 1'b0;
    check("rand_wr_cycles", W'(wr_cycles), W'(24));
    check("rand_tile_cnt", W'(bus.tile_cnt_o), W'(3));
    check("rand_err", W'(bus.err_o), W'(0));
    wait_ready("rand_drain_exit");

    // Flush after five beats
    for (int i = 0; i < 5; i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i = vecs[i].data;
      step();
      check("pre_flush_wr_en", W'(bus.wr_en_o), W'(vecs[i].exp_wen));
    end
    bus.s_data_i = vecs[5].data;
    bus.flush_i = 1'b1;
    #1;
    check("flush_s_ready", W'(bus.s_ready_o), W'(0));
    step();
    bus.flush_i = 1'b0;
    bus.s_valid_i = 1'b0;
    check("flush_drop_beat", W'(bus.wr_en_o), W'(0));
    check("flush_rd_en", W'(bus.rd_en_o), W'(1));
    check("flush_drain_ready", W'(bus.s_ready_o), W'(0));
    step();
    check("flush_rd_single", W'(bus.rd_en_o), W'(0));
    wait_ready("flush_drain_exit");
    send_beat(vecs[0].data);
    check("refill_pattern", W'(bus.wr_en_o), W'(4'b0101));
    check("flush_tile_cnt", W'(bus.tile_cnt_o), W'(3));

    // Flush and accept together in PRESENT
    for (int i = 1; i < 8; i++) send_beat(vecs[i].data);
    wait_tile("flush_accept_present");
    bus.flush_i = 1'b1;
    bus.tile_ready_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.tile_ready_i = 1'b0;
    check("fa_rd_en", W'(bus.rd_en_o), W'(1));
    check("fa_tile_valid", W'(bus.tile_valid_o), W'(0));
    check("fa_tile_cnt", W'(bus.tile_cnt_o), W'(3));
    step();
    check("fa_rd_single", W'(bus.rd_en_o), W'(0));
    wait_ready("fa_drain_exit");

    // Write into a quadrant already reporting full
    force_full = 1'b1;
    check("err_before", W'(bus.err_o), W'(0));
    send_beat(vecs[2].data);
    check("err_set", W'(bus.err_o), W'(1));
    check("err_write_forwarded", W'(bus.wr_en_o), W'(4'b0101));
    force_full = 1'b0;
    step();
    step();
    step();
    check("err_sticky", W'(bus.err_o), W'(1));
    do_reset();
    check("err_cleared", W'(bus.err_o), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tile_load_ctrl.md
# tile_load_ctrl

Write-side sequencer for the four-quadrant tiling buffer. It accepts a valid/ready stream of `SIZE_OF_INPUT`-bit beats and drives the buffer's per-quadrant write enables and write data in a fixed fill order. When all four SIPOs report full, it presents the tile downstream with a valid/ready handshake. On acceptance it issues the buffer read/release pulse and waits for all quadrants to empty before loading the next tile.

## Interface
- `SIZE_OF_INPUT`, 128, beat width; low half feeds quadrants 0/1, high half feeds quadrants 2/3
- `SIZE_OF_BUFFER`, 8, tile depth; each quadrant holds `DEPTH = SIZE_OF_BUFFER/2` half-beats
- `CNT_WIDTH`, 16, width of tile counter

- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `s_valid_i` in 1: input beat valid.
- `s_ready_o` out 1: controller can take a beat.
- `s_data_i` in `SIZE_OF_INPUT`: input beat.
- `wr_en_o` out 4: per-quadrant write enable to the buffer.
- `wr_data_o` out `SIZE_OF_INPUT`: write data to the buffer.
- `rd_en_o` out 1: one-cycle release pulse to the buffer.
- `is_empty_i` in 4: per-quadrant empty from the buffer.
- `is_full_i` in 4: per-quadrant full from the buffer.
- `tile_valid_o` out 1: full tile available on the buffer's read data.
- `tile_ready_i` in 1: downstream consumes the tile.
- `flush_i` in 1: abort the current tile and release the buffer.
- `tile_cnt_o` out `CNT_WIDTH`: accepted tiles, wraps modulo 2^`CNT_WIDTH`.
- `err_o` out 1: sticky protocol error.

## Operation
- FSM states: FILL_A, FILL_B, WAIT_FULL, PRESENT, DRAIN. Reset state is FILL_A.
- FILL_A:
  - `s_ready_o`=1. Each accepted beat writes quadrants 0 and 2 (pattern 4'b0101).
  - A beat counter `bcnt` (0..DEPTH-1) advances per accepted beat.
  - On the DEPTH-th beat, clear `bcnt` and go to FILL_B.
- FILL_B:
  - `s_ready_o`=1. Same as FILL_A with pattern 4'b1010 (quadrants 1 and 3).
  - On the DEPTH-th beat, go to WAIT_FULL.
- WAIT_FULL: `s_ready_o`=0. Go to PRESENT when `is_full_i`==4'hF.
- PRESENT:
  - `tile_valid_o`=1.
  - When `tile_ready_i`=1, pulse `rd_en_o` for exactly one cycle, increment `tile_cnt_o`, and go to DRAIN.
- DRAIN: `s_ready_o`=0. Go to FILL_A when `is_empty_i`==4'hF.
- Flush: `flush_i`=1 in any state forces DRAIN next cycle and clears `bcnt`.
  - A one-cycle `rd_en_o` pulse is issued unless the FSM is already in DRAIN.
  - The in-flight beat is dropped and `s_ready_o` is forced 0 that cycle.
  - Flush has priority over `tile_ready_i`; a tile flushed in PRESENT is not counted.
- `s_ready_o` is combinational from state and `flush_i` only. It never depends on `s_valid_i`.
- Error: `err_o` sets when an accepted beat targets a quadrant whose `is_full_i` bit is already 1. It is cleared only by `rst_i`. The write is still forwarded.

## Timing
- Reset values:
  - state=FILL_A, `bcnt`=0
  - `wr_en_o`=0, `wr_data_o`=0, `rd_en_o`=0
  - `tile_valid_o`=0, `tile_cnt_o`=0, `err_o`=0
  - `s_ready_o`=1 in the first cycle after reset.
- `wr_en_o` and `wr_data_o` are registered, one cycle after the s-handshake.
  - `wr_en_o`=0 on cycles with no handshake. `wr_data_o` holds its last value.
- `tile_valid_o` and `rd_en_o` are registered from state.
  - `tile_valid_o` rises the cycle after WAIT_FULL observes 4'hF.
  - `tile_valid_o` falls the cycle after acceptance, which is the same cycle `rd_en_o`=1.
- Minimum tile period is 2*DEPTH write cycles + 1 (WAIT_FULL) + 1 (PRESENT) + 1 (DRAIN), plus the buffer's full/empty latency.
- Back-to-back beats at full rate are accepted with no bubbles across the FILL_A→FILL_B transition.
- Reset mid-fill discards all progress; no `rd_en_o` pulse is generated by reset.

## Test plan
- Reset, then 8 consecutive beats 0x…01–0x…08 with DEPTH=4:
  - `wr_en_o` is 4'b0101 ×4, then 4'b1010 ×4, each one cycle after its handshake.
  - `wr_data_o` equals the beats in order.
  - `tile_valid_o` rises after full.
- `tile_ready_i` held 0 for 10 cycles in PRESENT:
  - `tile_valid_o` is stable at 1, `s_ready_o`=0, no `wr_en_o`.
  - Then `tile_ready_i`=1: a single `rd_en_o` pulse and `tile_cnt_o`=1.
- Random `s_valid_i` gaps (50%) over 3 tiles: exactly 24 write cycles, `tile_cnt_o`=3, `err_o`=0.
- `flush_i` after 5 beats:
  - `s_ready_o`=0 that cycle, one `rd_en_o` pulse, DRAIN.
  - The next tile refills from quadrant pattern 4'b0101. `tile_cnt_o` is unchanged.
- `flush_i` and `tile_ready_i` asserted together in PRESENT: one `rd_en_o` pulse, `tile_cnt_o` is not incremented.
- `is_full_i` forced to 4'b0001 during FILL_A with a beat accepted: `err_o`=1 and stays 1 until `rst_i`.
